// File: rtl/adc_spi_reader.sv
// adc_spi_reader: periodic SPI master for a 12-bit AD7476-class ADC (16 SCLK frame, MSB first).
// Optional ADC_AVG4_EN: report the truncated mean of every 4 frames instead of each frame.
module adc_spi_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int QUIET_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        adc_sdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] sample,
  output logic        adc_complete,
  output logic        busy
);
  localparam int DATA_W     = 12;
  localparam int HALF_EDGES = 32;
  localparam int PER_W      = $clog2(SAMPLE_PERIOD + 1);
  localparam int CNT_MAX    = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int DIV_W      = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, CONVERT, QUIET} state_t;

  state_t              state_q, state_d;
  logic [PER_W-1:0]    period_q, period_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [5:0]          edge_q, edge_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                complete_q, complete_d;

  logic trigger, frame_done, quiet_done;

`ifdef ADC_AVG4_EN
  localparam int ACC_W = DATA_W + 2;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [ACC_W-1:0] frame_sum;

  function automatic logic [DATA_W-1:0] avg4_trunc(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:2];
  endfunction
`endif

  assign trigger    = enable && (period_q == '0);
  assign frame_done = (state_q == CONVERT) && (edge_q == 6'(HALF_EDGES));
  assign quiet_done = (state_q == QUIET) && (div_q == DIV_W'(QUIET_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      period_q   <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      shift_q    <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      sample_q   <= '0;
      complete_q <= 1'b0;
`ifdef ADC_AVG4_EN
      acc_q      <= '0;
      fcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      shift_q    <= shift_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      sample_q   <= sample_d;
      complete_q <= complete_d;
`ifdef ADC_AVG4_EN
      acc_q      <= acc_d;
      fcnt_q     <= fcnt_d;
`endif
    end
  end

  // Triggers arriving outside IDLE are simply ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger)    state_d = CONVERT;
      CONVERT: if (frame_done) state_d = QUIET;
      QUIET:   if (quiet_done) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    period_d   = '0;
    div_d      = div_q;
    edge_d     = edge_q;
    shift_d    = shift_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    sample_d   = sample_q;
    complete_d = 1'b0;
    if (enable)
      period_d = (period_q == PER_W'(SAMPLE_PERIOD - 1)) ? '0 : period_q + PER_W'(1);
`ifdef ADC_AVG4_EN
    acc_d     = acc_q;
    fcnt_d    = fcnt_q;
    frame_sum = acc_q + ACC_W'(shift_q);
`endif

    case (state_q)
      IDLE: begin
        div_d  = '0;
        edge_d = '0;
        if (trigger) cs_n_d = 1'b0;
      end
      CONVERT: begin
        if (frame_done) begin
          cs_n_d = 1'b1;
          sclk_d = 1'b1;
          div_d  = '0;
`ifndef ADC_AVG4_EN
          sample_d   = shift_q;
          complete_d = 1'b1;
`endif
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d  = '0;
          edge_d = edge_q + 6'd1;
          sclk_d = ~sclk_q;
          // Only 12 bits are kept: the 4 leading zeros fall off the top.
          if (!sclk_q) shift_d = {shift_q[DATA_W-2:0], adc_sdata};
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      QUIET: div_d = quiet_done ? '0 : div_q + DIV_W'(1);
      default: div_d = '0;
    endcase

`ifdef ADC_AVG4_EN
    if (!enable) begin
      acc_d  = '0;
      fcnt_d = '0;
    end else if (frame_done) begin
      if (fcnt_q == 2'd3) begin
        sample_d   = avg4_trunc(frame_sum);
        complete_d = 1'b1;
        acc_d      = '0;
        fcnt_d     = '0;
      end else begin
        acc_d  = frame_sum;
        fcnt_d = fcnt_q + 2'd1;
      end
    end
`endif
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample       = sample_q;
  assign adc_complete = complete_q;
  assign busy         = (state_q != IDLE);

endmodule
